// File: rtl/seq_addsub_unit.sv
// Multi-cycle signed adder/subtractor. Operands are consumed SLICE_W bits per
// clock, least-significant slice first, with a registered carry rippling
// between slices. Valid/ready handshake on both the operand and result sides.
module seq_addsub_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE_W{1'b1}});

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_base;
  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W:0] w_slice_sum;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_acc_next;

  // Slice datapath: select the current slice, add it, and merge it back.
  assign w_base      = 32'(r_idx) * 32'(SLICE_W);
  assign w_a_shift   = r_a >> w_base;
  assign w_b_shift   = r_b >> w_base;
  assign w_a_slice   = w_a_shift[SLICE_W-1:0];
  assign w_b_slice   = w_b_shift[SLICE_W-1:0];
  assign w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE_W{1'b0}}, r_carry};
  // Carry into the top bit of the slice, recovered from its sum bit.
  assign w_msb_cin   = w_slice_sum[SLICE_W-1] ^ w_a_slice[SLICE_W-1] ^ w_b_slice[SLICE_W-1];
  assign w_acc_next  = (r_acc & ~(SLICE_MASK << w_base))
                     | (WIDTH'(w_slice_sum[SLICE_W-1:0]) << w_base);
  assign w_last      = (r_idx == LAST_IDX);
  assign w_accept    = in_valid && w_in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StBusy;
      StBusy:  if (w_last) w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Handshake output decode; depends on state only.
  always_comb begin
    w_in_ready = 1'b0;
    if (r_state == StIdle) w_in_ready = 1'b1;
  end

  // Operand capture, slice accumulation and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_out_sum   <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_a     <= in_a;
            // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub;
            r_idx   <= '0;
          end
        end
        StBusy: begin
          r_acc   <= w_acc_next;
          r_carry <= w_slice_sum[SLICE_W];
          if (w_last) begin
            r_idx       <= '0;
            r_out_sum   <= w_acc_next;
            r_cout      <= w_slice_sum[SLICE_W];
            r_ovf       <= w_msb_cin ^ w_slice_sum[SLICE_W];
            r_zero      <= (w_acc_next == '0);
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        StDone: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Bench for seq_addsub_unit: directed cases with literal expectations plus a
// randomized phase, all checked each cycle against a behavioural model.
module tb_seq_addsub_unit;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SLICE_W = 8;
  localparam int unsigned NSLICE  = WIDTH / SLICE_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  always #5 clk = ~clk;

  seq_addsub_unit #(
    .WIDTH  (WIDTH),
    .SLICE_W(SLICE_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain wide add/subtract and sign-rule overflow.
  task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input bit sub,
                        output logic [31:0] s, output bit co, output bit ov, output bit z);
    logic [32:0] w;
    if (sub) begin
      w  = {1'b0, a} - {1'b0, b};
      co = ~w[32];
      ov = (a[31] != b[31]) && (w[31] != a[31]);
    end else begin
      w  = {1'b0, a} + {1'b0, b};
      co = w[32];
      ov = (a[31] == b[31]) && (w[31] != a[31]);
    end
    s = w[31:0];
    z = (s == 32'd0);
  endtask

  // Behavioural model: one operation in flight, result appears NSLICE edges after accept.
  bit          m_busy, m_valid;
  int          m_cnt;
  logic [31:0] m_sum, p_sum;
  bit          m_cout, m_ovf, m_zero, p_cout, p_ovf, p_zero;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_cnt = 0;
      m_sum = 32'd0; m_cout = 0; m_ovf = 0; m_zero = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0; m_valid = 1;
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf; m_zero = p_zero;
      end
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (in_valid) begin
      ref_op(in_a, in_b, in_sub, p_sum, p_cout, p_ovf, p_zero);
      m_busy = 1;
      m_cnt  = NSLICE;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  in_ready,  !m_busy && !m_valid);
      chk("out_valid", out_valid, m_valid);
      chk("out_sum",   out_sum,   m_sum);
      chk("out_cout",  out_cout,  m_cout);
      chk("out_ovf",   out_ovf,   m_ovf);
      chk("out_zero",  out_zero,  m_zero);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", in_ready, 1);
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sub,
                        input logic [31:0] e_sum, input bit e_cout, input bit e_ovf,
                        input bit e_zero, input string tag);
    wait_ready();
    in_valid = 1; in_a = a; in_b = b; in_sub = sub;
    @(negedge clk);
    // Scramble operands after accept; the unit must ignore them.
    in_valid = 0; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
    wait_result(tag);
    chk({tag, "_sum"},   out_sum,  e_sum);
    chk({tag, "_cout"},  out_cout, e_cout);
    chk({tag, "_ovf"},   out_ovf,  e_ovf);
    chk({tag, "_zero"},  out_zero, e_zero);
    chk({tag, "_msum"},  m_sum,    e_sum);
    chk({tag, "_mcout"}, m_cout,   e_cout);
    chk({tag, "_movf"},  m_ovf,    e_ovf);
  endtask

  task automatic release_result();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("release_in_ready", in_ready, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; in_valid = 0; in_a = '0; in_b = '0; in_sub = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_sum",   out_sum, 0);
    chk("rst_flags", {out_cout, out_ovf, out_zero}, 0);

    run_op(32'h8000_0001, 32'h8000_0001, 0, 32'h0000_0002, 1, 1, 0, "add_negneg");
    release_result();
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 32'hFFFF_FFFE, 0, 1, 0, "add_pospos");
    release_result();
    run_op(32'h70FF_9FFC, 32'hF2FD_9FFC, 0, 32'h63FD_3FF8, 1, 0, 0, "add_mixed");
    release_result();
    run_op(32'd5, 32'd7, 1, 32'hFFFF_FFFE, 0, 0, 0, "sub_5_7");
    release_result();
    run_op(32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1, 1, 0, "sub_min_1");
    release_result();
    run_op(32'h1234_5678, 32'h1234_5678, 1, 32'h0000_0000, 1, 0, 1, "sub_equal");
    release_result();
    run_op(32'h0000_0000, 32'h8000_0000, 1, 32'h8000_0000, 0, 1, 0, "sub_0_min");
    release_result();

    // Backpressure with a competing request held during BUSY and DONE.
    wait_ready();
    in_valid = 1; in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_sub = 0;
    @(negedge clk);
    in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001;
    wait_result("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_sum", out_sum, 32'h3333_3333);
      chk("bp_flags", {out_cout, out_ovf, out_zero}, 0);
    end
    in_valid = 0;
    release_result();

    // Reset two edges after accept, with a request offered during reset.
    wait_ready();
    in_valid = 1; in_a = 32'h0F0F_0F0F; in_b = 32'h0101_0101; in_sub = 0;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1; in_valid = 1; in_a = 32'd1; in_b = 32'd1; in_sub = 0;
    @(negedge clk);
    rst = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_sum", out_sum, 0);
    chk("abort_flags", {out_cout, out_ovf, out_zero}, 0);
    chk("abort_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    wait_result("after_abort");
    chk("after_abort_sum", out_sum, 32'h0000_0002);
    release_result();

    // Randomized traffic with occasional resets and random backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = pick();
      in_b      = pick();
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (8) @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_addsub_unit.md
Name: seq_addsub_unit

Overview:
- Multi-cycle signed 32-bit adder/subtractor with a valid/ready handshake on both sides.
- Processes the operands SLICE_W bits per clock, least-significant slice first, rippling a registered carry between slices.
- Reports sum, carry-out, signed overflow and zero: the producer-side arithmetic unit whose flags the adder benches check.
- Sits between an operand source (sequencer/register file) and a result consumer.

Parameters:
WIDTH, 32, operand/result width in bits; must be an integer multiple of SLICE_W.
SLICE_W, 8, bits processed per BUSY cycle; NSLICE = WIDTH/SLICE_W.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  unit can accept operands
in_a  input  WIDTH  operand A (two's complement)
in_b  input  WIDTH  operand B (two's complement)
in_sub  input  1  0: A+B, 1: A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  result
out_cout  output  1  carry out of MSB (for subtraction: 1 = no borrow)
out_ovf  output  1  signed overflow
out_zero  output  1  out_sum == 0

Behaviour:
- Clocking: one clock, clk. rst is synchronous, active-high, sampled on the rising edge.
- Reset values: state IDLE; out_valid=0; out_sum=0; out_cout=0; out_ovf=0; out_zero=0; slice index=0; carry register=0.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). It is a combinational decode of state only and does not depend on in_valid.
- IDLE, accept: on an edge with in_valid&&in_ready:
  - latch A into a_reg; latch B into b_reg, inverted when in_sub=1;
  - carry register <= in_sub;
  - index <= 0; go BUSY.
- Operands are sampled only at the accept edge. Later changes on in_* are ignored.
- BUSY: each edge adds slice[index] of a_reg, b_reg and the carry register, then:
  - writes that slice of the sum register;
  - updates the carry register with the slice carry-out;
  - index++.
- BUSY, last slice: on the edge for index NSLICE-1:
  - out_cout <= carry out of bit WIDTH-1;
  - out_ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - out_zero <= (full sum == 0);
  - out_valid <= 1; go DONE.
- Latency: the accept edge is T. out_valid rises at edge T+NSLICE (T+4 at defaults).
- DONE: out_sum and all flags stay stable while out_valid=1.
  - On an edge with out_ready=1: out_valid <= 0, go IDLE. Outputs keep their last values.
  - out_ready=0 holds DONE indefinitely, with no timeout.
- Throughput: one operation per NSLICE+2 cycles minimum. No overlap between operations: in_ready=0 in BUSY and DONE.
- Overflow is carry-based for both operations. Subtracting the most-negative value is covered without special-casing. Example: 0 - 0x80000000 → sum 0x80000000, ovf=1.
- Wrap-around: the sum is modulo 2^WIDTH. out_cout reports the discarded bit.
- Reset mid-operation, in BUSY or DONE: abort the operation and return all registers to reset values on that edge. No out_valid pulse for the aborted operation.
- rst has priority over in_valid and out_ready in the same cycle.
- in_valid=1 during rst: not accepted. It can be accepted on the first edge after rst deasserts.

Test Plan:
- ADD, in_a=0x80000001, in_b=0x80000001 -> out_sum=0x00000002, cout=1, ovf=1, zero=0; out_valid exactly 4 cycles after accept.
- ADD, in_a=0x7FFFFFFF, in_b=0x7FFFFFFF -> out_sum=0xFFFFFFFE, cout=0, ovf=1.
- ADD, in_a=0x70FF9FFC, in_b=0xF2FD9FFC -> out_sum=0x63FD3FF8, cout=1, ovf=0.
- SUB, 5-7 -> out_sum=0xFFFFFFFE, cout=0, ovf=0. SUB, 0x80000000-1 -> 0x7FFFFFFF, cout=1, ovf=1. SUB, 0x12345678-0x12345678 -> 0, cout=1, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: result and flags stable; in_ready=0 throughout.
  - Then pulse out_ready=1 for one cycle: in_ready=1 the next cycle.
  - A new in_valid offered during BUSY must not be accepted.
- Reset abort: assert rst for 1 cycle 2 cycles after accept.
  - Required: all outputs 0 and in_ready=1 next cycle; no out_valid for the aborted operation.
  - A following ADD 1+1 must return 0x00000002.
